param_register_file: RTL and testbench

//  Parametrised general-purpose register file for the datapath.

---
 rtl/param_register_file.sv | 101 ++++++++++
 tb/tb_param_register_file.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
// General-purpose register file: two registered read ports with write bypass, one write port,
// blocked-write fault flag/counter and per-register pending-write (busy) scoreboard.
module param_register_file #(
    parameter int                        DATA_W    = 32,
    parameter int                        ADDR_W    = 5,
    parameter logic [(2**ADDR_W)-1:0]    PROT_MASK = 32'h0C00_0000,
    parameter int                        SP_INDEX  = 29,
    parameter int                        SP_INIT   = 1023,
    parameter int                        FCNT_W    = 8
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [ADDR_W-1:0]        ReadReg1,
    input  logic [ADDR_W-1:0]        ReadReg2,
    output logic signed [DATA_W-1:0] ReadData1,
    output logic signed [DATA_W-1:0] ReadData2,
    output logic                     Busy1,
    output logic                     Busy2,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WAddr,
    input  logic signed [DATA_W-1:0] WData,
    input  logic                     ResvEn,
    input  logic [ADDR_W-1:0]        ResvAddr,
    output logic                     WriteFault,
    output logic [FCNT_W-1:0]        FaultCount
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic              busy1_q, busy1_d, busy2_q, busy2_d;
    logic              fault_q, fault_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              wr_acc, resv_acc;

    always_comb begin
        wr_acc   = RegWrite && (WAddr != '0) && !PROT_MASK[WAddr];
        resv_acc = ResvEn && (ResvAddr != '0) && !PROT_MASK[ResvAddr];

        regs_d = regs_q;
        if (wr_acc) begin
            regs_d[WAddr] = WData;
        end

        // Reserve is applied after the write-back clear so a same-cycle reserve wins.
        busy_d = busy_q;
        if (wr_acc) begin
            busy_d[WAddr] = 1'b0;
        end
        if (resv_acc) begin
            busy_d[ResvAddr] = 1'b1;
        end

        // Reading next-state storage gives the write-to-read bypass for free.
        rd1_d   = (ReadReg1 == '0) ? '0 : regs_d[ReadReg1];
        rd2_d   = (ReadReg2 == '0) ? '0 : regs_d[ReadReg2];
        busy1_d = busy_d[ReadReg1];
        busy2_d = busy_d[ReadReg2];

        fault_d = RegWrite && !wr_acc;
        fcnt_d  = fcnt_q;
        if (fault_d && (fcnt_q != '1)) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? DATA_W'(SP_INIT) : '0;
            end
            busy_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            busy1_q <= 1'b0;
            busy2_q <= 1'b0;
            fault_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            regs_q  <= regs_d;
            busy_q  <= busy_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            busy1_q <= busy1_d;
            busy2_q <= busy2_d;
            fault_q <= fault_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign ReadData1  = rd1_q;
    assign ReadData2  = rd2_q;
    assign Busy1      = busy1_q;
    assign Busy2      = busy2_q;
    assign WriteFault = fault_q;
    assign FaultCount = fcnt_q;

endmodule

// File: tb/tb_param_register_file.sv
// Randomized scoreboard bench for param_register_file against an array-based reference model.
module tb_param_register_file;

    logic               Clk = 1'b0;
    logic               Rst_n = 1'b1;
    logic [4:0]         ReadReg1 = '0, ReadReg2 = '0, WAddr = '0, ResvAddr = '0;
    logic signed [31:0] ReadData1, ReadData2, WData = '0;
    logic               Busy1, Busy2, RegWrite = 1'b0, ResvEn = 1'b0, WriteFault;
    logic [7:0]         FaultCount;

    param_register_file dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Busy1(Busy1), .Busy2(Busy2),
        .RegWrite(RegWrite), .WAddr(WAddr), .WData(WData),
        .ResvEn(ResvEn), .ResvAddr(ResvAddr),
        .WriteFault(WriteFault), .FaultCount(FaultCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic signed [31:0] rd1;
        logic signed [31:0] rd2;
        bit                 b1;
        bit                 b2;
        bit                 wf;
        int                 fc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // Reference model state
    int          m_reg  [32];
    bit          m_busy [32];
    int          m_fc;
    logic [31:0] prot_mask = 32'h0C00_0000;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit writable(input int a);
        return (a != 0) && (prot_mask[a] == 1'b0);
    endfunction

    task automatic model_reset();
        foreach (m_reg[i]) begin
            m_reg[i]  = 0;
            m_busy[i] = 0;
        end
        m_reg[29] = 1023;
        m_fc      = 0;
    endtask

    // Apply one cycle of stimulus and queue the response expected after the next edge.
    task automatic step(input bit we, input int wa, input int wd,
                        input bit re, input int ra, input int r1, input int r2);
        exp_t e;
        @(negedge Clk);
        RegWrite = we;  WAddr = wa[4:0];  WData = wd;
        ResvEn   = re;  ResvAddr = ra[4:0];
        ReadReg1 = r1[4:0]; ReadReg2 = r2[4:0];
        if (we && writable(wa)) begin
            m_reg[wa]  = wd;
            m_busy[wa] = 0;
        end
        if (re && writable(ra)) m_busy[ra] = 1;
        e.wf = we && !writable(wa);
        if (e.wf && m_fc < 255) m_fc++;
        e.fc  = m_fc;
        e.rd1 = (r1 == 0) ? 0 : m_reg[r1];
        e.rd2 = (r2 == 0) ? 0 : m_reg[r2];
        e.b1  = m_busy[r1];
        e.b2  = m_busy[r2];
        sb_q.push_back(e);
    endtask

    task automatic idle(input int r1, input int r2);
        step(0, 0, 0, 0, 0, r1, r2);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd1"}, ReadData1, 0);
        check({tag, "_rd2"}, ReadData2, 0);
        check({tag, "_busy1"}, Busy1, 0);
        check({tag, "_busy2"}, Busy2, 0);
        check({tag, "_wfault"}, WriteFault, 0);
        check({tag, "_fcount"}, FaultCount, 0);
    endtask

    // Monitor: every edge the DUT presents a fresh output set; compare against the oldest entry.
    always @(posedge Clk) begin
        #1;
        if (Rst_n && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("rd1", ReadData1, e.rd1);
            check("rd2", ReadData2, e.rd2);
            check("busy1", Busy1, longint'(e.b1));
            check("busy2", Busy2, longint'(e.b2));
            check("wfault", WriteFault, longint'(e.wf));
            check("fcount", FaultCount, e.fc);
        end
    end

    initial begin
        model_reset();
        #1 Rst_n = 1'b0;
        #2 check_outputs_zero("por");
        @(negedge Clk);
        Rst_n = 1'b1;

        // Reset values of reg 0 and the stack pointer
        idle(0, 29);
        // Write with same-cycle read bypass, then hold
        step(1, 5, -7, 0, 0, 5, 0);
        idle(5, 5);
        // Blocked writes to 0, 26, 27; registers stay 0
        step(1, 0, 11, 0, 0, 26, 27);
        step(1, 26, 22, 0, 0, 26, 27);
        step(1, 27, 33, 0, 0, 26, 27);
        idle(26, 27);
        // Scoreboard: reserve, write-back clears, reserve+write keeps busy
        step(0, 0, 0, 1, 8, 8, 9);
        idle(8, 8);
        step(0, 0, 0, 1, 8, 8, 0);
        step(1, 8, 42, 0, 0, 8, 8);
        step(1, 8, 43, 1, 8, 8, 5);
        idle(8, 0);
        // Reserves of reg 0 and protected regs are ignored without a fault
        step(0, 0, 0, 1, 26, 26, 0);
        step(0, 0, 0, 1, 0, 0, 27);

        // Randomized traffic, addresses drawn over the full range including 0/26/27
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 31), int'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31));
        end

        // Drive the fault counter well past saturation
        for (int i = 0; i < 300; i++) begin
            step(1, (i % 3 == 0) ? 0 : 26 + (i % 2), i, 0, 0, 5, 29);
        end
        step(1, 5, 1234, 1, 12, 5, 12);
        idle(5, 12);

        // Asynchronous reset between edges while a write and reserve are being presented
        @(negedge Clk);
        RegWrite = 1'b1; WAddr = 5'd5; WData = 99;
        ResvEn = 1'b1; ResvAddr = 5'd9; ReadReg1 = 5'd5; ReadReg2 = 5'd9;
        #2 Rst_n = 1'b0;
        #1 check_outputs_zero("arst");
        model_reset();
        RegWrite = 1'b0; ResvEn = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        idle(5, 9);
        idle(12, 29);

        @(negedge Clk);
        @(negedge Clk);
        check("queue_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
